// File: rtl/fib_lanes_pkg.sv
// Shared types and helpers for the multi-lane Fibonacci generator.
package fib_lanes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LANES_MAX = 8;

  // Bit offset of lane i inside a packed beat of w-bit lanes.
  function automatic int lane_slice(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/fib_term_chain.sv
// Combinational Fibonacci term chain: expands (a, b) into LANES+2 terms
// together with sticky wrap flags that propagate forward along the chain.
module fib_term_chain
  import fib_lanes_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 2
) (
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  logic                       ovf_a,
  input  logic                       ovf_b,
  output logic [LANES+1:0][W-1:0]    t,
  output logic [LANES+1:0]           o
);

  logic [W:0] sum;

  // The extra top bit of each sum is the carry that marks a wrapped term.
  always_comb begin
    t    = '0;
    o    = '0;
    sum  = '0;
    t[0] = a;
    t[1] = b;
    o[0] = ovf_a;
    o[1] = ovf_b;
    for (int i = 2; i < LANES + 2; i++) begin
      sum  = {1'b0, t[i-1]} + {1'b0, t[i-2]};
      t[i] = sum[W-1:0];
      o[i] = sum[W] | o[i-1] | o[i-2];
    end
  end

endmodule

// File: rtl/fibonacci_lanes.sv
// Fibonacci stream source: LANES consecutive terms per beat on a valid/ready
// interface, stopping after the first beat that contains a wrapped term.
module fibonacci_lanes
  import fib_lanes_pkg::*;
#(
  parameter int W     = 16,
  parameter int LANES = 2,
  parameter int IDX_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         seed_a,
  input  logic [W-1:0]         seed_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*W-1:0]   out_num,
  output logic                 out_ovf,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 done
);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d;
  logic               ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [LANES+1:0][W-1:0] t;
  logic [LANES+1:0]        o;
  logic                    accept;

  fib_term_chain #(.W(W), .LANES(LANES)) u_chain (
    .a     (a_q),
    .b     (b_q),
    .ovf_a (ovf_a_q),
    .ovf_b (ovf_b_q),
    .t     (t),
    .o     (o)
  );

  assign accept = (state_q == RUN) && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ovf_a_q <= ovf_a_d;
      ovf_b_q <= ovf_b_d;
      idx_q   <= idx_d;
    end
  end

  // start overrides everything, including a beat accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (start)                   state_d = RUN;
        else if (accept && out_ovf)  state_d = DONE;
      end
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    ovf_a_d = ovf_a_q;
    ovf_b_d = ovf_b_q;
    idx_d   = idx_q;
    if (start) begin
      a_d     = seed_a;
      b_d     = seed_b;
      ovf_a_d = 1'b0;
      ovf_b_d = 1'b0;
      idx_d   = '0;
    end else if (accept) begin
      a_d     = t[LANES];
      b_d     = t[LANES+1];
      ovf_a_d = o[LANES];
      ovf_b_d = o[LANES+1];
      idx_d   = idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    out_valid = (state_q == RUN);
    done      = (state_q == DONE);
    out_idx   = idx_q;
    out_ovf   = |o[LANES-1:0];
    out_num   = '0;
    for (int i = 0; i < LANES; i++) begin
      out_num[lane_slice(i, W) +: W] = t[i];
    end
  end

endmodule

// File: tb/tb_fibonacci_lanes.sv
// Self-checking bench: four generator configurations driven from a table of
// expected beats through a scoreboard queue, plus restart and reset sequences.
module tb_fibonacci_lanes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance map: 0 = W16/L2, 1 = W8/L2, 2 = W16/L3, 3 = W16/L1
  logic        rst_v   [4];
  logic        start_v [4];
  logic        ready_v [4];
  logic [15:0] sa_v    [4];
  logic [15:0] sb_v    [4];
  logic        valid_v [4];
  logic        ovf_v   [4];
  logic        done_v  [4];
  logic [15:0] idx_v   [4];
  logic [63:0] num_v   [4];

  logic [31:0] n0;
  logic [15:0] n1;
  logic [47:0] n2;
  logic [15:0] n3;
  logic [7:0]  sa8, sb8;

  assign sa8      = sa_v[1][7:0];
  assign sb8      = sb_v[1][7:0];
  assign num_v[0] = {32'b0, n0};
  assign num_v[1] = {48'b0, n1};
  assign num_v[2] = {16'b0, n2};
  assign num_v[3] = {48'b0, n3};

  fibonacci_lanes #(.W(16), .LANES(2), .IDX_W(16)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .seed_a(sa_v[0]), .seed_b(sb_v[0]),
    .out_valid(valid_v[0]), .out_ready(ready_v[0]), .out_num(n0), .out_ovf(ovf_v[0]),
    .out_idx(idx_v[0]), .done(done_v[0]));

  fibonacci_lanes #(.W(8), .LANES(2), .IDX_W(16)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .seed_a(sa8), .seed_b(sb8),
    .out_valid(valid_v[1]), .out_ready(ready_v[1]), .out_num(n1), .out_ovf(ovf_v[1]),
    .out_idx(idx_v[1]), .done(done_v[1]));

  fibonacci_lanes #(.W(16), .LANES(3), .IDX_W(16)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .seed_a(sa_v[2]), .seed_b(sb_v[2]),
    .out_valid(valid_v[2]), .out_ready(ready_v[2]), .out_num(n2), .out_ovf(ovf_v[2]),
    .out_idx(idx_v[2]), .done(done_v[2]));

  fibonacci_lanes #(.W(16), .LANES(1), .IDX_W(16)) u3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .seed_a(sa_v[3]), .seed_b(sb_v[3]),
    .out_valid(valid_v[3]), .out_ready(ready_v[3]), .out_num(n3), .out_ovf(ovf_v[3]),
    .out_idx(idx_v[3]), .done(done_v[3]));

  typedef struct {
    int          tc;
    logic [15:0] idx;
    logic [63:0] num;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] num;
    logic        ovf;
    logic [15:0] idx;
  } beat_t;

  vec_t  tbl[$];
  beat_t sb_q[$];
  beat_t held;
  bit    hold_pending;
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [63:0] pk(input int w, input longint l0, input longint l1,
                                     input longint l2);
    return 64'(l0) | (64'(l1) << w) | (64'(l2) << (2 * w));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input int tc, input int idx, input logic [63:0] num, input logic ovf);
    vec_t v;
    v.tc  = tc;
    v.idx = 16'(idx);
    v.num = num;
    v.ovf = ovf;
    tbl.push_back(v);
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input int inst, input bit st, input logic [15:0] sa,
                               input logic [15:0] sb, input bit rdy);
    @(posedge clk);
    #1;
    start_v[inst] = st;
    sa_v[inst]    = sa;
    sb_v[inst]    = sb;
    ready_v[inst] = rdy;
  endtask

  // Sample on the falling edge: stalled beats must hold, accepted beats are scored.
  task automatic checkOutput(input int inst, input bit start_now);
    beat_t e;
    @(negedge clk);
    if (sb_q.size() == 0) return;
    chk("valid_no_bubble", 64'(valid_v[inst]), 64'(1));
    if (!valid_v[inst]) return;
    if (hold_pending && !start_now) begin
      chk("hold_num", num_v[inst], held.num);
      chk("hold_ovf", 64'(ovf_v[inst]), 64'(held.ovf));
      chk("hold_idx", 64'(idx_v[inst]), 64'(held.idx));
    end
    if (ready_v[inst]) begin
      e = sb_q.pop_front();
      chk("beat_num", num_v[inst], e.num);
      chk("beat_ovf", 64'(ovf_v[inst]), 64'(e.ovf));
      chk("beat_idx", 64'(idx_v[inst]), 64'(e.idx));
      hold_pending = 1'b0;
    end else begin
      held.num     = num_v[inst];
      held.ovf     = ovf_v[inst];
      held.idx     = idx_v[inst];
      hold_pending = 1'b1;
    end
  endtask

  // mode 0: ready always high; mode 1: ready low for two cycles then random.
  task automatic runStream(input int tc, input int inst, input logic [15:0] sa,
                           input logic [15:0] sb, input int mode, input int restart_at,
                           input logic [15:0] ra, input logic [15:0] rb);
    int cyc;
    bit rdy, st;
    hold_pending = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].tc == tc) sb_q.push_back('{num: tbl[i].num, ovf: tbl[i].ovf, idx: tbl[i].idx});
    end
    applyStimulus(inst, 1'b1, sa, sb, 1'b0);
    cyc = 0;
    while (sb_q.size() > 0 && cyc < 400) begin
      if (mode == 0)    rdy = 1'b1;
      else if (cyc < 2) rdy = 1'b0;
      else              rdy = 1'($urandom_range(0, 1));
      st = (cyc == restart_at);
      applyStimulus(inst, st, st ? ra : sa, st ? rb : sb, rdy);
      checkOutput(inst, st);
      cyc++;
    end
    if (sb_q.size() != 0) chk("stream_timeout", 64'(sb_q.size()), 64'(0));
    sb_q.delete();
    applyStimulus(inst, 1'b0, sa, sb, 1'b0);
  endtask

  initial begin
    int a, b, n;
    for (int i = 0; i < 4; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
      ready_v[i] = 1'b0;
      sa_v[i]    = '0;
      sb_v[i]    = '0;
    end

    addVec(0, 0, pk(16, 1, 1, 0), 1'b0);
    addVec(0, 1, pk(16, 2, 3, 0), 1'b0);
    addVec(0, 2, pk(16, 5, 8, 0), 1'b0);
    addVec(0, 3, pk(16, 13, 21, 0), 1'b0);

    addVec(1, 0, pk(16, 1, 1, 0), 1'b0);
    addVec(1, 1, pk(16, 2, 3, 0), 1'b0);
    addVec(1, 2, pk(16, 5, 8, 0), 1'b0);
    addVec(1, 0, pk(16, 2, 1, 0), 1'b0);
    addVec(1, 1, pk(16, 3, 4, 0), 1'b0);
    addVec(1, 2, pk(16, 7, 11, 0), 1'b0);

    addVec(2, 0, pk(8, 1, 1, 0), 1'b0);
    addVec(2, 1, pk(8, 2, 3, 0), 1'b0);
    addVec(2, 2, pk(8, 5, 8, 0), 1'b0);
    addVec(2, 3, pk(8, 13, 21, 0), 1'b0);
    addVec(2, 4, pk(8, 34, 55, 0), 1'b0);
    addVec(2, 5, pk(8, 89, 144, 0), 1'b0);
    addVec(2, 6, pk(8, 233, 121, 0), 1'b1);

    addVec(3, 0, pk(16, 1, 1, 2), 1'b0);
    addVec(3, 1, pk(16, 3, 5, 8), 1'b0);
    addVec(3, 2, pk(16, 13, 21, 34), 1'b0);
    addVec(3, 3, pk(16, 55, 89, 144), 1'b0);
    addVec(3, 4, pk(16, 233, 377, 610), 1'b0);

    addVec(4, 0, 64'(0), 1'b0);
    addVec(4, 1, 64'(0), 1'b0);
    addVec(4, 2, 64'(0), 1'b0);

    a = 1;
    b = 1;
    for (int k = 0; k < 25; k++) begin
      addVec(5, k, 64'(a & 32'hffff), (k == 24));
      n = a + b;
      a = b;
      b = n;
    end

    addVec(6, 0, pk(16, 1, 1, 0), 1'b0);
    addVec(6, 1, pk(16, 2, 3, 0), 1'b0);
    addVec(6, 2, pk(16, 5, 8, 0), 1'b0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", 64'(valid_v[i]), 64'(0));
      chk("rst_ovf",   64'(ovf_v[i]),   64'(0));
      chk("rst_idx",   64'(idx_v[i]),   64'(0));
      chk("rst_done",  64'(done_v[i]),  64'(0));
      chk("rst_num",   num_v[i],        64'(0));
    end

    runStream(0, 0, 16'd1, 16'd1, 0, -1, 16'd0, 16'd0);
    runStream(1, 0, 16'd1, 16'd1, 0, 2, 16'd2, 16'd1);

    runStream(2, 1, 16'd1, 16'd1, 0, -1, 16'd0, 16'd0);
    chk("w8_done",  64'(done_v[1]),  64'(1));
    chk("w8_valid", 64'(valid_v[1]), 64'(0));
    applyStimulus(1, 1'b0, 16'd1, 16'd1, 1'b1);
    chk("w8_done_hold", 64'(valid_v[1]), 64'(0));

    runStream(3, 2, 16'd1, 16'd1, 1, -1, 16'd0, 16'd0);
    runStream(4, 2, 16'd0, 16'd0, 0, -1, 16'd0, 16'd0);

    runStream(5, 3, 16'd1, 16'd1, 0, -1, 16'd0, 16'd0);
    chk("l1_done",  64'(done_v[3]),  64'(1));
    chk("l1_valid", 64'(valid_v[3]), 64'(0));

    applyStimulus(0, 1'b1, 16'd1, 16'd1, 1'b0);
    applyStimulus(0, 1'b0, 16'd1, 16'd1, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 64'(valid_v[0]), 64'(1));
    chk("pre_rst_num",   num_v[0],        pk(16, 1, 1, 0));
    @(posedge clk);
    #1;
    rst_v[0] = 1'b1;
    @(posedge clk);
    #1;
    rst_v[0] = 1'b0;
    chk("mid_rst_valid", 64'(valid_v[0]), 64'(0));
    chk("mid_rst_idx",   64'(idx_v[0]),   64'(0));
    chk("mid_rst_done",  64'(done_v[0]),  64'(0));
    runStream(6, 0, 16'd1, 16'd1, 0, -1, 16'd0, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
